// File: rtl/seq_divider_nb.sv
// Iterative restoring divider implementing RV32M DIV/DIVU/REM/REMU.
// One trial subtraction per cycle; constant N+3 cycle issue-to-issue latency.

module ripple_carry_adder_nb #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         inv_b_i,
    input  logic         carry_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);
    logic [W-1:0] w_b;
    logic [W:0]   w_c;

    assign w_b = b_i ^ {W{inv_b_i}};

    // inv_b_i supplies the +1 of the two's complement, so carry_i=0 gives a-b
    always_comb begin
        w_c    = '0;
        sum_o  = '0;
        w_c[0] = carry_i ^ inv_b_i;
        for (int i = 0; i < int'(W); i++) begin
            sum_o[i]  = a_i[i] ^ w_b[i] ^ w_c[i];
            w_c[i+1]  = (a_i[i] & w_b[i]) | (w_c[i] & (a_i[i] ^ w_b[i]));
        end
    end

    assign carry_o = w_c[W];
endmodule

module seq_divider_nb #(
    parameter int unsigned N = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         signed_i,
    input  logic         rem_i,
    input  logic [N-1:0] opa_i,
    input  logic [N-1:0] opb_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] res_o
);
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [N:0]     r_rem;
    logic [N-1:0]   r_quo;
    logic [N-1:0]   r_a_mag;
    logic [N-1:0]   r_b_mag;
    logic [CW-1:0]  r_cnt;
    logic           r_sign_a;
    logic           r_sign_b;
    logic           r_rem_sel;
    logic           r_signed;
    logic           r_busy;
    logic           r_done;
    logic [N-1:0]   r_res;

    logic [N-1:0]   w_a_mag;
    logic [N-1:0]   w_b_mag;
    logic [N:0]     w_t;
    logic [N:0]     w_d;
    logic           w_carry;
    logic           w_fit;
    logic           w_div0;
    logic           w_ovf;
    logic [N-1:0]   w_a_orig;
    logic [N-1:0]   w_quo_fix;
    logic [N-1:0]   w_rem_fix;

    assign w_a_mag = (signed_i && opa_i[N-1]) ? (N'(0) - opa_i) : opa_i;
    assign w_b_mag = (signed_i && opb_i[N-1]) ? (N'(0) - opb_i) : opb_i;

    assign w_t = {r_rem[N-1:0], r_quo[N-1]};

    ripple_carry_adder_nb #(.W(N + 1)) u_sub (
        .a_i     (w_t),
        .b_i     ({1'b0, r_b_mag}),
        .inv_b_i (1'b1),
        .carry_i (1'b0),
        .sum_o   (w_d),
        .carry_o (w_carry)
    );

    // R stays below the divisor, so R[N] is always 0; folding it in is harmless
    assign w_fit = w_carry | r_rem[N];

    assign w_div0   = (r_b_mag == '0);
    assign w_ovf    = r_signed && r_sign_a && r_sign_b &&
                      (r_a_mag == {1'b1, {(N-1){1'b0}}}) && (r_b_mag == N'(1));
    assign w_a_orig = r_sign_a ? (N'(0) - r_a_mag) : r_a_mag;

    // Sign correction and RISC-V special cases
    always_comb begin
        w_quo_fix = (r_sign_a ^ r_sign_b) ? (N'(0) - r_quo) : r_quo;
        w_rem_fix = r_sign_a ? (N'(0) - r_rem[N-1:0]) : r_rem[N-1:0];
        if (w_div0) begin
            w_quo_fix = '1;
            w_rem_fix = w_a_orig;
        end else if (w_ovf) begin
            w_quo_fix = {1'b1, {(N-1){1'b0}}};
            w_rem_fix = '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start_i) w_next = S_CALC;
            S_CALC: if (r_cnt == CW'(N - 1)) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_quo     <= '0;
            r_a_mag   <= '0;
            r_b_mag   <= '0;
            r_cnt     <= '0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_rem_sel <= 1'b0;
            r_signed  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_res     <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_CALC) || (w_next == S_FIX);
            r_done  <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_a_mag   <= w_a_mag;
                        r_b_mag   <= w_b_mag;
                        r_sign_a  <= signed_i & opa_i[N-1];
                        r_sign_b  <= signed_i & opb_i[N-1];
                        r_rem_sel <= rem_i;
                        r_signed  <= signed_i;
                        r_rem     <= '0;
                        r_quo     <= w_a_mag;
                        r_cnt     <= '0;
                    end
                end
                S_CALC: begin
                    r_rem <= w_fit ? w_d : w_t;
                    r_quo <= {r_quo[N-2:0], w_fit};
                    r_cnt <= (r_cnt == CW'(N - 1)) ? '0 : r_cnt + CW'(1);
                end
                S_FIX: begin
                    r_res <= r_rem_sel ? w_rem_fix : w_quo_fix;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign res_o  = r_res;
endmodule

// File: tb/tb_seq_divider_nb.sv
// Scoreboard bench for seq_divider_nb: issue tasks push expected results and
// done cycles, a negedge monitor pops and compares on each done_o pulse.

module tb_seq_divider_nb;
    localparam int N = 32;

    typedef struct {
        logic [N-1:0] res;
        int           cyc;
        string        name;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic         signed_i = 1'b0;
    logic         rem_i = 1'b0;
    logic [N-1:0] opa_i = '0;
    logic [N-1:0] opb_i = '0;
    logic         busy_o;
    logic         done_o;
    logic [N-1:0] res_o;

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t q[$];

    seq_divider_nb #(.N(N)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .signed_i (signed_i),
        .rem_i    (rem_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .res_o    (res_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding request
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i && done_o) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done actual=%h required=none", res_o);
            end else begin
                e = q.pop_front();
                chk(e.name, res_o, e.res);
                chk({e.name, "_cyc"}, N'(cyc), N'(e.cyc));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy_o || done_o) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic issue(input string nm, input logic sg, input logic rm,
                         input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] req, output int acc);
        wait_idle();
        start_i  = 1'b1;
        signed_i = sg;
        rem_i    = rm;
        opa_i    = a;
        opb_i    = b;
        @(posedge clk_i);
        @(negedge clk_i);
        acc = cyc;
        q.push_back('{res: req, cyc: acc + N + 1, name: nm});
        start_i = 1'b0;
        opa_i   = $urandom;
        opb_i   = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        if (q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout actual=%0d required=0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int acc;
        repeat (3) @(negedge clk_i);
        chk("rst_busy", N'(busy_o), N'(0));
        chk("rst_done", N'(done_o), N'(0));
        chk("rst_res",  res_o, '0);
        rst_i = 1'b0;
        @(negedge clk_i);

        issue("divu_100_7",   1'b0, 1'b0, 32'd100,        32'd7,          32'd14,         acc);
        issue("remu_100_7",   1'b0, 1'b1, 32'd100,        32'd7,          32'd2,          acc);
        issue("div_m7_2",     1'b1, 1'b0, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   acc);
        issue("rem_m7_2",     1'b1, 1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   acc);
        issue("rem_7_m2",     1'b1, 1'b1, 32'd7,          32'hFFFFFFFE,   32'd1,          acc);
        issue("divu_x_0",     1'b0, 1'b0, 32'h1234,       32'd0,          32'hFFFFFFFF,   acc);
        issue("rem_x_0",      1'b1, 1'b1, 32'h1234,       32'd0,          32'h1234,       acc);
        issue("div_m5_0",     1'b1, 1'b0, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   acc);
        issue("rem_m5_0",     1'b1, 1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   acc);
        issue("div_ovf",      1'b1, 1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   acc);
        issue("rem_ovf",      1'b1, 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          acc);
        issue("divu_max_1",   1'b0, 1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   acc);
        issue("divu_min_max", 1'b0, 1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          acc);
        issue("remu_min_max", 1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   acc);
        issue("div_m100_m7",  1'b1, 1'b0, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         acc);
        issue("rem_m100_m7",  1'b1, 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   acc);
        issue("divu_0_5",     1'b0, 1'b0, 32'd0,          32'd5,          32'd0,          acc);
        issue("remu_max_16",  1'b0, 1'b1, 32'hFFFFFFFF,   32'h10,         32'hF,          acc);
        drain();

        // start_i held high: second request accepted only once back in IDLE
        begin
            int a0;
            int n;
            wait_idle();
            start_i  = 1'b1;
            signed_i = 1'b0;
            rem_i    = 1'b0;
            opa_i    = 32'd1000;
            opb_i    = 32'd10;
            @(posedge clk_i);
            @(negedge clk_i);
            a0 = cyc;
            q.push_back('{res: 32'd100, cyc: a0 + N + 1,     name: "b2b_first"});
            q.push_back('{res: 32'd9,   cyc: a0 + 2 * N + 4, name: "b2b_second"});
            opa_i = 32'd81;
            opb_i = 32'd9;
            n = 0;
            while (cyc < a0 + N + 3 && n < 200) begin
                if (cyc == a0 + 5) chk("b2b_busy_calc", N'(busy_o), N'(1));
                if (cyc == a0 + N) chk("b2b_busy_fix", N'(busy_o), N'(1));
                if (cyc == a0 + N + 2) chk("b2b_idle_busy", N'(busy_o), N'(0));
                @(negedge clk_i);
                n++;
            end
            start_i = 1'b0;
            drain();
        end

        // Reset mid-CALC aborts the operation without a done pulse
        issue("rst_abort", 1'b0, 1'b0, 32'd50, 32'd3, 32'd16, acc);
        while (cyc < acc + 9) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("midrst_busy", N'(busy_o), N'(0));
        chk("midrst_done", N'(done_o), N'(0));
        chk("midrst_res",  res_o, '0);
        q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (N + 6) @(negedge clk_i);
        issue("post_rst_divu", 1'b0, 1'b0, 32'd50, 32'd3, 32'd16, acc);
        issue("post_rst_remu", 1'b0, 1'b1, 32'd50, 32'd3, 32'd2,  acc);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
